// File: rtl/lift_pkg.sv
// +--------------------------------------------------------------------+
// | lift_pkg: shared lift controller constants (line indices, defaults) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package lift_pkg;

  localparam int N_IN         = 14;
  localparam int DEBOUNCE_DEF = 4;
  localparam logic [N_IN-1:0] STICKY_MASK_DEF = 14'h0600;

  localparam int X1_IDX  = 0;
  localparam int X2_IDX  = 1;
  localparam int X3_IDX  = 2;
  localparam int X4_IDX  = 3;
  localparam int X5_IDX  = 4;
  localparam int X6_IDX  = 5;
  localparam int X7_IDX  = 6;
  localparam int X8_IDX  = 7;
  localparam int X9_IDX  = 8;
  localparam int X10_IDX = 9;
  localparam int X11_IDX = 10;
  localparam int X12_IDX = 11;
  localparam int X13_IDX = 12;
  localparam int X14_IDX = 13;

  typedef logic [N_IN-1:0] lift_vec_t;

  // Debounce counter width: must hold 0..DEBOUNCE.
  function automatic int cnt_width(input int db);
    return $clog2(db + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lift_debounce_bit.sv
// +--------------------------------------------------------------------+
// | lift_debounce_bit: 2-flop sync plus counter debounce for one line    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module lift_debounce_bit
  import lift_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_d,
  output logic o_rise
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_d;
  logic [CW-1:0] r_cnt;

  logic w_diff;
  logic w_accept;

  assign w_diff   = (r_sync != r_d);
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_d    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_d   <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_d = r_d;
  // Asserted during the cycle whose closing edge moves d from 0 to 1.
  assign o_rise = w_accept & r_sync;

endmodule

`default_nettype wire

// File: rtl/lift_input_conditioner.sv
// +--------------------------------------------------------------------+
// | lift_input_conditioner: per-line debounce, sticky call latches,     |
// | change strobe and pending flag for the lift controller. Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module lift_input_conditioner #(
  parameter int              N_IN        = lift_pkg::N_IN,
  parameter int              DEBOUNCE    = lift_pkg::DEBOUNCE_DEF,
  parameter logic [N_IN-1:0] STICKY_MASK = lift_pkg::STICKY_MASK_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  input  logic [N_IN-1:0] clr,
  output logic [N_IN-1:0] x,
  output logic            chg,
  output logic            pend
);

  logic [N_IN-1:0] w_d;
  logic [N_IN-1:0] w_rise;
  logic [N_IN-1:0] w_x;
  logic [N_IN-1:0] r_sticky;
  logic [N_IN-1:0] r_x_prev;
  logic            r_chg;
  logic            r_pend;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_line
    lift_debounce_bit #(
      .DEBOUNCE (DEBOUNCE)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (raw_in[gi]),
      .o_d    (w_d[gi]),
      .o_rise (w_rise[gi])
    );
  end

  // Latches run on every line; only sticky lines route them to x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= w_rise | (r_sticky & ~clr);
    end
  end

  assign w_x = (r_sticky & STICKY_MASK) | (w_d & ~STICKY_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_prev <= '0;
      r_chg    <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_x_prev <= w_x;
      r_chg    <= |(w_x ^ r_x_prev);
      r_pend   <= |(w_x & STICKY_MASK);
    end
  end

  assign x    = w_x;
  assign chg  = r_chg;
  assign pend = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_lift_input_conditioner.sv
// +--------------------------------------------------------------------+
// | tb_lift_input_conditioner: directed + random bench with a window-  |
// | based reference model of the conditioner. Rev 1.0                  |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lift_input_conditioner;

  localparam int              N    = 14;
  localparam int              DB   = 4;
  localparam logic [N-1:0]    MASK = 14'h0600;
  localparam int unsigned     WIN  = (1 << DB) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw_in;
  logic [N-1:0] clr;
  logic [N-1:0] x;
  logic         chg;
  logic         pend;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: raw pipeline, accepted levels, sticky latches,
  // and per-line history of synchronised samples (newest in bit 0).
  logic [N-1:0] m_meta, m_s, m_d, m_st, m_x_prev;
  logic         m_chg, m_pend;
  int unsigned  hist [N];

  always #5 clk = ~clk;

  lift_input_conditioner #(
    .N_IN        (N),
    .DEBOUNCE    (DB),
    .STICKY_MASK (MASK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .clr    (clr),
    .x      (x),
    .chg    (chg),
    .pend   (pend)
  );

  function automatic logic [N-1:0] m_x();
    return (m_st & MASK) | (m_d & ~MASK);
  endfunction

  task automatic model_reset();
    m_meta = '0; m_s = '0; m_d = '0; m_st = '0; m_x_prev = '0;
    m_chg = 1'b0; m_pend = 1'b0;
    for (int i = 0; i < N; i++) hist[i] = 0;
  endtask

  // A line flips once its last DB synchronised samples all disagree with d.
  task automatic model_edge();
    logic [N-1:0] xpre;
    logic         rise;
    xpre     = m_x();
    m_chg    = (xpre != m_x_prev);
    m_pend   = |(xpre & MASK);
    m_x_prev = xpre;
    for (int i = 0; i < N; i++) begin
      hist[i] = (hist[i] << 1) | int'(m_s[i]);
      rise    = 1'b0;
      if ((hist[i] & WIN) == (m_d[i] ? 0 : WIN)) begin
        rise   = !m_d[i];
        m_d[i] = !m_d[i];
      end
      if (rise)        m_st[i] = 1'b1;
      else if (clr[i]) m_st[i] = 1'b0;
    end
    m_s    = m_meta;
    m_meta = raw_in;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_x",    x,           m_x());
    chk("model_chg",  N'(chg),     N'(m_chg));
    chk("model_pend", N'(pend),    N'(m_pend));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    raw_in = '0;
    clr    = '0;
    rst    = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset_x",    x,        '0);
    chk("reset_chg",  N'(chg),  '0);
    chk("reset_pend", N'(pend), '0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    steps(3);

    // Clean press on x1: accepted at the 6th edge, chg after the 7th.
    raw_in[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk("press_x0",  N'(x[0]), N'(n >= 6));
      chk("press_chg", N'(chg),  N'(n == 7));
    end
    chk("press_others", x & ~14'h0001, '0);

    // Glitch of 3 cycles rejected, 4 cycles accepted.
    raw_in[1] = 1'b1; steps(3);
    raw_in[1] = 1'b0; steps(8);
    chk("glitch3_x1", N'(x[1]), '0);
    raw_in[1] = 1'b1; steps(4);
    raw_in[1] = 1'b0; steps(4);
    chk("glitch4_x1", N'(x[1]), 14'd1);
    steps(6);

    // Sticky x10: survives release, cleared by clr, pend follows an edge later.
    raw_in[9] = 1'b1; steps(6);
    raw_in[9] = 1'b0; steps(8);
    chk("sticky_hold", N'(x[9]), 14'd1);
    chk("sticky_pend", N'(pend), 14'd1);
    clr[9] = 1'b1; step(); clr[9] = 1'b0;
    chk("sticky_clr_x",    N'(x[9]), '0);
    chk("sticky_clr_pend", N'(pend), 14'd1);
    step();
    chk("sticky_pend_drop", N'(pend), '0);

    // Set/clear collision on x11: clr only at the accepting edge.
    raw_in[10] = 1'b1; steps(5);
    clr[10] = 1'b1; step(); clr[10] = 1'b0;
    chk("collide_set", N'(x[10]), 14'd1);
    for (int n = 0; n < 4; n++) begin
      clr[10] = 1'b1; step(); clr[10] = 1'b0; steps(2);
    end
    chk("collide_held_clr", N'(x[10]), '0);
    raw_in[10] = 1'b0; steps(6);

    // clr on a non-sticky line is ignored.
    raw_in[2] = 1'b1; steps(8);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("nonsticky_clr_x", N'(x[2]), 14'd1);
    step();
    chk("nonsticky_clr_chg", N'(chg), '0);

    // Reset mid-count on x4 with x10 latched.
    raw_in[9] = 1'b1; steps(6); raw_in[9] = 1'b0; steps(2);
    raw_in[3] = 1'b1; steps(4);
    #3 rst = 1'b1;
    #1;
    chk("midrst_x",    x,        '0);
    chk("midrst_chg",  N'(chg),  '0);
    chk("midrst_pend", N'(pend), '0);
    #1 rst = 1'b0;
    model_reset();
    for (int n = 1; n <= 7; n++) begin
      step();
      chk("midrst_relatch_x3", N'(x[3]), N'(n >= 6));
    end
    chk("midrst_no_replay_x9", N'(x[9]), '0);

    // Random traffic: sparse toggles and acknowledges.
    for (int n = 0; n < 400; n++) begin
      raw_in = raw_in ^ N'($urandom & $urandom & $urandom);
      clr    = N'($urandom & $urandom & $urandom);
      step();
    end
    clr = '0;
    steps(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
